// File: rtl/mbuf_inst_queue.sv
// mbuf_inst_queue: FIFO between the MBUF/MTBUF decoder and the memory pipeline.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset (clears pointers and count)
//   mbuf_inst_in   decoded instruction from the MBUF decoder
//   in_valid       decoder valid; held high while the decoder is stalled
//   stall_out      queue full, stalls the MBUF decoder
//   flush          discards all queued entries
//   mbuf_inst_out  head entry to the memory pipeline
//   out_valid      mbuf_inst_out is valid
//   out_ready      memory pipeline accepts the head entry
//   count          number of stored entries
//
// Optional feature: define MBUF_QUEUE_BYPASS_EN to forward the decoder's entry
// combinationally to the output when the queue is empty.

typedef struct packed {
   logic [7:0]  opcode;
   logic [7:0]  vdata;
   logic [7:0]  vaddr;
   logic [4:0]  srsrc;
   logic [6:0]  soffset;
   logic [11:0] offset;
} mbuf_inst_t;

module mbuf_inst_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  mbuf_inst_t       mbuf_inst_in,
   input  logic             in_valid,
   output logic             stall_out,
   input  logic             flush,
   output mbuf_inst_t       mbuf_inst_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned      PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Payload storage is deliberately not reset.
   mbuf_inst_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic push;
   logic pop;
   logic queue_valid;

   assign stall_out   = (count_q == FULL_CNT);
   assign queue_valid = (count_q != '0);
   assign count       = count_q;

`ifdef MBUF_QUEUE_BYPASS_EN
   logic bypass;

   // Empty queue: present the decoder's entry directly. If the pipeline takes
   // it in the same cycle it is never stored.
   assign bypass        = !queue_valid && in_valid && !flush;
   assign out_valid     = queue_valid || bypass;
   assign mbuf_inst_out = bypass ? mbuf_inst_in : mem[rd_ptr_q];
   assign push          = in_valid && !stall_out && !flush && !(bypass && out_ready);
`else
   assign out_valid     = queue_valid;
   assign mbuf_inst_out = mem[rd_ptr_q];
   assign push          = in_valid && !stall_out && !flush;
`endif

   // Only a stored entry is popped; a bypassed entry never touches the pointers.
   assign pop = queue_valid && out_ready && !flush;

   // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 naturally.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr_q] <= mbuf_inst_in;
      end
   end

endmodule

// File: tb/tb_mbuf_inst_queue.sv
// Scoreboard bench for mbuf_inst_queue (default build, bypass disabled).
// The driver pushes every entry the queue should accept into exp_q; the
// monitor compares the DUT's outputs at each falling edge against exp_q.
module tb_mbuf_inst_queue;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned INST_W = 48;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [INST_W-1:0] inst_in = '0;
   logic              in_valid = 1'b0;
   logic              stall_out;
   logic              flush = 1'b0;
   logic [INST_W-1:0] inst_out;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CNT_W-1:0]  count;

   always #5 clk = ~clk;

   mbuf_inst_queue #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mbuf_inst_in  (inst_in),
      .in_valid      (in_valid),
      .stall_out     (stall_out),
      .flush         (flush),
      .mbuf_inst_out (inst_out),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .count         (count)
   );

   logic [INST_W-1:0] exp_q[$];
   int                checks = 0;
   int                errors = 0;
   bit                started = 1'b0;
   int unsigned       size_at_start = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: actual %h required %h", name, $time, act, req);
      end
   endtask

   function automatic logic [INST_W-1:0] mk(input logic [11:0] off);
      logic [31:0] hi;
      logic [3:0]  mid;
      hi  = $urandom();
      mid = 4'($urandom());
      return {hi, mid, off};
   endfunction

   // One clock cycle of stimulus, then the reference update for the edge
   // that ends the cycle: queue semantics straight from the accept rules.
   task automatic drive(input bit iv, input logic [INST_W-1:0] d, input bit ordy,
                        input bit fl, input bit rs);
      @(posedge clk);
      #1;
      in_valid  = iv;
      inst_in   = d;
      out_ready = ordy;
      flush     = fl;
      reset     = rs;
      @(negedge clk);
      #1;
      if (rs || fl) begin
         exp_q.delete();
      end else if (iv && size_at_start < DEPTH) begin
         exp_q.push_back(d);
      end
   endtask

   // Monitor: outputs reflect the state at the start of the cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            size_at_start = exp_q.size();
            check("count", 64'(count), 64'(size_at_start));
            check("stall_out", 64'(stall_out), 64'(size_at_start == DEPTH));
            check("out_valid", 64'(out_valid), 64'(size_at_start != 0));
            if (size_at_start != 0) begin
               check("head_data", 64'(inst_out), 64'(exp_q[0]));
               if (out_ready && !flush && !reset) begin
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [INST_W-1:0] held;

      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, mk(12'h111), 1'b1, 1'b0, 1'b1);
      started = 1'b1;

      // Push order: fill with 0x001..0x004, then drain.
      for (int i = 1; i <= 4; i++) drive(1'b1, mk(12'(i)), 1'b0, 1'b0, 1'b0);
      drive(1'b1, mk(12'h0ff), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Held valid against a full queue: exactly one more accept after a pop.
      for (int i = 1; i <= 4; i++) drive(1'b1, mk(12'(16 + i)), 1'b0, 1'b0, 1'b0);
      held = mk(12'h055);
      for (int i = 0; i < 3; i++) drive(1'b1, held, 1'b0, 1'b0, 1'b0);
      drive(1'b1, held, 1'b1, 1'b0, 1'b0);
      drive(1'b1, held, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Simultaneous push and pop at count 2.
      for (int i = 0; i < 2; i++) drive(1'b1, mk(12'(32 + i)), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, mk(12'(48 + i)), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Flush with in_valid high at count 3.
      for (int i = 0; i < 3; i++) drive(1'b1, mk(12'(64 + i)), 1'b0, 1'b0, 1'b0);
      drive(1'b1, mk(12'h0aa), 1'b1, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Reset mid-stream at count 2.
      for (int i = 0; i < 2; i++) drive(1'b1, mk(12'(80 + i)), 1'b0, 1'b0, 1'b0);
      drive(1'b1, mk(12'h0bb), 1'b1, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(99) < 70, mk(12'($urandom())), $urandom_range(99) < 55,
               $urandom_range(99) < 3, $urandom_range(199) == 0);
      end

      for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mbuf_inst_queue.md
MBUF_INST_QUEUE -- requirements
Module: mbuf_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; a power of two, 2 to 16.
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, width of the occupancy count.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port mbuf_inst_in, input, mbuf_inst_t, the decoded MBUF/MTBUF instruction from the MBUF decoder.
REQ-006 SHALL have port in_valid, input, 1, the decoder's valid; it is held high while the decoder is stalled.
REQ-007 SHALL have port stall_out, output, 1, driven to the MBUF decoder stall input.
REQ-008 SHALL have port flush, input, 1, discards all queued entries.
REQ-009 SHALL have port mbuf_inst_out, output, mbuf_inst_t, the head entry sent to the memory pipeline.
REQ-010 SHALL have port out_valid, output, 1, asserted when mbuf_inst_out is valid.
REQ-011 SHALL have port out_ready, input, 1, the memory pipeline accepts the head entry.
REQ-012 SHALL have port count, output, CNT_W, the number of stored entries.

Function
REQ-013 SHALL decode stall_out combinationally from registered state as (count == DEPTH).
REQ-014 SHALL define push = in_valid && !stall_out && !flush, so a held in_valid is accepted exactly once, in the cycle stall_out is low.
REQ-015 SHALL define pop = out_valid && out_ready && !flush.
REQ-016 SHALL store the entry at the write pointer on push, and SHALL advance the read pointer on pop; both pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 SHALL update count as: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-018 SHALL never push when full and never pop when empty.
REQ-019 SHALL drive out_valid = (count != 0) and mbuf_inst_out from the entry at the read pointer (first in, first out).
REQ-020 SHALL hold mbuf_inst_out and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL, when full with a pop in the same cycle, perform no push that cycle (stall_out is high); count becomes DEPTH-1 and stall_out deasserts the next cycle.
REQ-022 SHALL, on flush, set count and both pointers to 0 at the next edge; flush dominates push and pop in that cycle.
REQ-023 SHALL drive out_valid low in the cycle after a flush.
REQ-024 SHALL have a latency of 1 cycle from push to out_valid when the queue is empty and MBUF_QUEUE_BYPASS_EN is undefined.
REQ-025 SHALL leave stored data payloads unreset; only the pointers and count are reset.

Reset
REQ-026 SHALL, when reset is sampled high, clear count, write pointer and read pointer to 0.
REQ-027 SHALL drive out_valid=0, stall_out=0 and count=0 in the cycle after reset.
REQ-028 SHALL discard any entry in flight when reset is asserted mid-operation; no push or pop SHALL occur in a reset cycle.

Configuration
REQ-029 SHALL recognise macro MBUF_QUEUE_BYPASS_EN.
REQ-030 SHALL, when MBUF_QUEUE_BYPASS_EN is defined and count==0 and in_valid && !flush: drive out_valid=1 and mbuf_inst_out=mbuf_inst_in combinationally; if out_ready is also high, the entry SHALL NOT be stored and count SHALL stay 0.
REQ-031 SHALL, when MBUF_QUEUE_BYPASS_EN is undefined, have no combinational path from in_valid or mbuf_inst_in to the outputs.

Verification
REQ-032 SHALL cover push order: with DEPTH=4 and out_ready=0, push entries with offset 0x001..0x004 -> count=4, stall_out=1; then out_ready=1 -> outputs 0x001,0x002,0x003,0x004 on consecutive cycles, count returns to 0.
REQ-033 SHALL cover held-valid with stall: queue full and in_valid held high for 3 cycles, then one pop -> exactly one further push when stall_out drops; count reaches 4 again, no duplicate entry.
REQ-034 SHALL cover simultaneous push and pop: with count=2, push and pop together for 5 cycles -> count stays 2 and output order is preserved.
REQ-035 SHALL cover flush: with count=3, flush together with in_valid=1 -> count=0 and out_valid=0 the next cycle; the input entry is dropped.
REQ-036 SHALL cover reset mid-stream: reset with count=2 and out_valid=1 -> count=0, out_valid=0, stall_out=0 the next cycle.
REQ-037 SHALL cover bypass (macro defined): empty queue, in_valid=1 with offset=0x0AB and out_ready=1 -> out_valid=1 with offset 0x0AB in the same cycle, count stays 0; with the macro undefined, out_valid rises one cycle later.
